// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
// Holds the controller state encodings and the default datapath width shared with the ALU.
package serial_addsub_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle between the ALU control FSM and the serial add/sub unit.
//   master: drives start, sub, a, b; observes busy, done, result, cout, overflow, zero.
//   slave : the serial unit, the mirror image.
interface serial_addsub_ctrl_if
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_addsub_ctrl_add1b.sv
// add1b: one-bit full adder, the single datapath slice of the serial unit.
//   a, b, ci : addend bits and carry in
//   r, co    : sum bit and carry out
module add1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic co,
    output logic r
);
    assign r  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: runs one add1b slice over WIDTH cycles, LSB first,
// with a registered carry, and presents the result plus flags behind a start/busy/done handshake.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave): start/sub/a/b in; busy/done/result/cout/overflow/zero out (all registered)
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_addsub_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa_sr, opa_nxt;
    logic [WIDTH-1:0] opb_sr, opb_nxt;
    logic [WIDTH-1:0] res_sr, res_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             carry, carry_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             cout_q, cout_nxt;
    logic             ovf_q, ovf_nxt;
    logic             zero_q, zero_nxt;
    logic             slice_co, slice_sum;

    add1b u_slice (
        .a  (opa_sr[0]),
        .b  (opb_sr[0]),
        .ci (carry),
        .co (slice_co),
        .r  (slice_sum)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            opa_sr <= '0;
            opb_sr <= '0;
            res_sr <= '0;
            count  <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            opa_sr <= opa_nxt;
            opb_sr <= opb_nxt;
            res_sr <= res_nxt;
            count  <= count_nxt;
            carry  <= carry_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            cout_q <= cout_nxt;
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
        end
    end

    // Next-state, datapath and flag logic
    always_comb begin
        state_nxt = state;
        opa_nxt   = opa_sr;
        opb_nxt   = opb_sr;
        res_nxt   = res_sr;
        count_nxt = count;
        carry_nxt = carry;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        cout_nxt  = cout_q;
        ovf_nxt   = ovf_q;
        zero_nxt  = zero_q;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                    state_nxt = ST_RUN;
                    opa_nxt   = bus.a;
                    opb_nxt   = bus.sub ? ~bus.b : bus.b;
                    carry_nxt = bus.sub;
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_nxt   = {slice_sum, res_sr[WIDTH-1:1]};
                opa_nxt   = opa_sr >> 1;
                opb_nxt   = opb_sr >> 1;
                carry_nxt = slice_co;
                count_nxt = count + CNT_W'(1);
                if (count == LAST_BIT) begin
                    // carry still holds the carry into the MSB here
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cout_nxt  = slice_co;
                    ovf_nxt   = carry ^ slice_co;
                    zero_nxt  = (res_nxt == '0);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = res_sr;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;

endmodule
